// File: rtl/wide_alu_seq_pkg.sv
// Shared i8080-style definitions: flag bit positions, opcodes, FSM state
// encodings and the operating modes of the serial slice.
package wide_alu_seq_pkg;

  // Flag register bit positions (i8080 PSW layout)
  localparam int FS = 7;
  localparam int FZ = 6;
  localparam int FA = 4;
  localparam int FP = 2;
  localparam int FC = 0;

  // Operation codes
  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_ADC = 4'd1;
  localparam logic [3:0] OP_SUB = 4'd2;
  localparam logic [3:0] OP_SBB = 4'd3;
  localparam logic [3:0] OP_AND = 4'd4;
  localparam logic [3:0] OP_XOR = 4'd5;
  localparam logic [3:0] OP_OR  = 4'd6;
  localparam logic [3:0] OP_CMP = 4'd7;
  localparam logic [3:0] OP_INC = 4'd8;
  localparam logic [3:0] OP_DEC = 4'd9;
  localparam logic [3:0] OP_DAD = 4'd10;
  localparam logic [3:0] OP_RLC = 4'd11;
  localparam logic [3:0] OP_RAL = 4'd12;

  // Sequencer states
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // What the slice does with its operands
  typedef enum logic [2:0] {
    SL_ADD = 3'd0,
    SL_AND = 3'd1,
    SL_XOR = 3'd2,
    SL_OR  = 3'd3,
    SL_ROT = 3'd4
  } slice_mode_e;

endpackage

// File: rtl/alu_slice.sv
// One XLEN-wide slice: adder with carry in/out and nibble carry, bitwise
// logic, and a one-bit left shift whose carry links slices into a rotate.
module alu_slice import wide_alu_seq_pkg::*; #(
  parameter int XLEN = 8
) (
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            cin,
  input  slice_mode_e     mode,
  output logic [XLEN-1:0] y,
  output logic            cout,
  output logic            c3
);

  logic [XLEN:0] sum;
  logic [4:0]    low;

  // Select the slice function; carry passes through untouched for logic ops
  always_comb begin
    sum  = {1'b0, a} + {1'b0, b} + {{XLEN{1'b0}}, cin};
    low  = {1'b0, a[3:0]} + {1'b0, b[3:0]} + {4'b0, cin};
    y    = sum[XLEN-1:0];
    cout = sum[XLEN];
    c3   = low[4];
    case (mode)
      SL_AND: begin y = a & b; cout = cin; c3 = 1'b0; end
      SL_XOR: begin y = a ^ b; cout = cin; c3 = 1'b0; end
      SL_OR:  begin y = a | b; cout = cin; c3 = 1'b0; end
      SL_ROT: begin y = {a[XLEN-2:0], cin}; cout = a[XLEN-1]; c3 = 1'b0; end
      default: ;
    endcase
  end

endmodule

// File: rtl/wide_alu_seq.sv
// Multi-word i8080-style ALU: captures a request, walks one slice per
// cycle LSB first through a single alu_slice, then holds the response.
module wide_alu_seq import wide_alu_seq_pkg::*; #(
  parameter int XLEN  = 8,
  parameter int WORDS = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [3:0]            op,
  input  logic [XLEN*WORDS-1:0] op_a,
  input  logic [XLEN*WORDS-1:0] op_b,
  input  logic [XLEN-1:0]       flags_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [XLEN*WORDS-1:0] result,
  output logic [XLEN-1:0]       flags_out,
  output logic                  out_err
);

  localparam int W  = XLEN * WORDS;
  localparam int CW = (WORDS > 1) ? $clog2(WORDS) : 1;

  logic [1:0]      state;
  logic [CW-1:0]   cnt;
  logic [3:0]      op_q;
  logic [W-1:0]    a_q, b_q, res_q, res_nxt, res_fin;
  logic [XLEN-1:0] fl_q, fl_nxt;
  logic            carry_q, fa_q, fa_use, err_nxt;
  logic            accept, last, sub_op;
  logic [XLEN-1:0] sl_a, sl_b, sl_y;
  logic            sl_cout, sl_c3;
  slice_mode_e     sl_mode;

  // Carry entering the least significant slice for each operation
  function automatic logic chain_init(input logic [3:0] o, input logic msb,
                                      input logic fc);
    case (o)
      OP_ADC:                 chain_init = fc;
      OP_SUB, OP_CMP, OP_DEC: chain_init = 1'b1;
      OP_SBB:                 chain_init = ~fc;
      OP_RLC:                 chain_init = msb;
      OP_RAL:                 chain_init = fc;
      default:                chain_init = 1'b0;
    endcase
  endfunction

  assign in_ready  = (state == ST_IDLE);
  assign out_valid = (state == ST_DONE);
  assign accept    = in_valid && in_ready;
  assign last      = (cnt == CW'(WORDS - 1));
  assign sub_op    = (op_q == OP_SUB) || (op_q == OP_SBB) ||
                     (op_q == OP_CMP) || (op_q == OP_DEC);
  assign sl_a      = a_q[int'(cnt)*XLEN +: XLEN];
  assign sl_b      = sub_op ? ~b_q[int'(cnt)*XLEN +: XLEN] : b_q[int'(cnt)*XLEN +: XLEN];

  // Map the captured opcode onto a slice mode
  always_comb begin
    sl_mode = SL_ADD;
    case (op_q)
      OP_AND:         sl_mode = SL_AND;
      OP_XOR:         sl_mode = SL_XOR;
      OP_OR:          sl_mode = SL_OR;
      OP_RLC, OP_RAL: sl_mode = SL_ROT;
      default:        ;
    endcase
  end

  alu_slice #(.XLEN(XLEN)) u_slice (
    .a    (sl_a),
    .b    (sl_b),
    .cin  (carry_q),
    .mode (sl_mode),
    .y    (sl_y),
    .cout (sl_cout),
    .c3   (sl_c3)
  );

  // Merge this cycle's slice into the accumulated word and derive final flags
  always_comb begin
    res_nxt = res_q;
    res_nxt[int'(cnt)*XLEN +: XLEN] = sl_y;
    fa_use  = (cnt == '0) ? sl_c3 : fa_q;
    fl_nxt  = fl_q;
    err_nxt = 1'b0;
    if (op_q <= OP_DEC) begin
      fl_nxt[FZ] = (res_nxt == '0);
      fl_nxt[FS] = res_nxt[W-1];
      fl_nxt[FP] = ~^res_nxt;
    end
    case (op_q)
      OP_ADD, OP_ADC:         begin fl_nxt[FC] = sl_cout;  fl_nxt[FA] = fa_use; end
      OP_SUB, OP_SBB, OP_CMP: begin fl_nxt[FC] = ~sl_cout; fl_nxt[FA] = fa_use; end
      OP_AND, OP_XOR, OP_OR:  begin fl_nxt[FC] = 1'b0;     fl_nxt[FA] = 1'b0;   end
      OP_INC, OP_DEC:         fl_nxt[FA] = fa_use;
      OP_DAD, OP_RLC, OP_RAL: fl_nxt[FC] = sl_cout;
      default:                err_nxt = 1'b1;
    endcase
    res_fin = ((op_q == OP_CMP) || err_nxt) ? a_q : res_nxt;
  end

  // Sequencer and response registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      result    <= '0;
      flags_out <= '0;
      out_err   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (in_valid) begin
          state <= ST_EXEC;
          cnt   <= '0;
        end
        ST_EXEC: if (last) begin
          state     <= ST_DONE;
          result    <= res_fin;
          flags_out <= fl_nxt;
          out_err   <= err_nxt;
        end else begin
          cnt <= cnt + 1'b1;
        end
        ST_DONE: if (out_ready) state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Request capture and per-slice datapath state
  always_ff @(posedge clk) begin
    if (accept) begin
      op_q    <= op;
      a_q     <= op_a;
      b_q     <= ((op == OP_INC) || (op == OP_DEC)) ? W'(1) : op_b;
      fl_q    <= flags_in;
      carry_q <= chain_init(op, op_a[W-1], flags_in[FC]);
    end else if (state == ST_EXEC) begin
      res_q   <= res_nxt;
      carry_q <= sl_cout;
      if (cnt == '0) fa_q <= sl_c3;
    end
  end

endmodule

// File: doc/wide_alu_seq.md
WIDE_ALU_SEQ -- requirements
Module: wide_alu_seq

Interface
REQ-001 SHALL have parameter XLEN, default 8, meaning slice width and flag-register width.
REQ-002 SHALL have parameter WORDS, default 2, meaning slice count; W = XLEN*WORDS is the operand width.
REQ-003 SHALL have port clk  input  1  rising-edge clock.
REQ-004 SHALL have port rst  input  1  reset; asynchronous, active-high.
REQ-005 SHALL have port in_valid  input  1  request valid.
REQ-006 SHALL have port in_ready  output  1  request accepted when in_valid&in_ready.
REQ-007 SHALL have port op  input  4  operation code.
REQ-008 SHALL have ports op_a and op_b  input  W  operands.
REQ-009 SHALL have port flags_in  input  XLEN  incoming flags, laid out with i8080.vh FS/FZ/FA/FP/FC indices.
REQ-010 SHALL have port out_valid  output  1  response valid.
REQ-011 SHALL have port out_ready  input  1  response consumed when out_valid&out_ready.
REQ-012 SHALL have port result  output  W  operation result.
REQ-013 SHALL have port flags_out  output  XLEN  updated flags.
REQ-014 SHALL have port out_err  output  1  reserved opcode flag.

Function
REQ-015 SHALL use FSM IDLE -> EXEC on accept; EXEC -> DONE after WORDS cycles; DONE -> IDLE on out_valid&out_ready.
REQ-016 SHALL register op, op_a, op_b and flags_in at accept; input changes afterwards SHALL be ignored.
REQ-017 SHALL drive in_ready=1 only in IDLE, and out_valid=1 only in DONE.
REQ-018 SHALL process one XLEN slice per EXEC cycle, LSB slice first, chaining carry/borrow between slices.
REQ-019 SHALL make result and flags_out valid on the first DONE cycle and hold them stable until the handshake completes.
REQ-020 SHALL implement opcodes: 0 ADD, 1 ADC, 2 SUB, 3 SBB, 4 AND, 5 XOR, 6 OR, 7 CMP, 8 INC, 9 DEC, 10 DAD, 11 RLC, 12 RAL.
REQ-021 SHALL take carry-in to the word LSB as FC for ADC, FC as borrow for SBB, and 0 otherwise.
REQ-022 SHALL set FC on SUB/SBB/CMP when a borrow occurs, i.e. unsigned op_a < op_b + borrow_in.
REQ-023 SHALL return result = op_a for CMP and update flags as for SUB.
REQ-024 SHALL compute INC/DEC as op_a±1 modulo 2^W with FC unchanged.
REQ-025 SHALL compute DAD as op_a+op_b and change only FC.
REQ-026 SHALL rotate the whole W-bit word left by 1 for RLC (bit0=old MSB, FC=old MSB) and for RAL (bit0=old FC, FC=old MSB), changing no other flag.
REQ-027 SHALL compute FA for arithmetic ops as carry out of bit 3 of slice 0, using the inverted-borrow adder for subtract forms; AND/XOR/OR SHALL clear FC and FA.
REQ-028 SHALL compute FZ=(result==0), FS=result[W-1] and FP=even parity of all W result bits for ops 0-9.
REQ-029 SHALL pass through all flags_out bits not named in REQ-021..028 from flags_in.
REQ-030 SHALL treat opcodes 13-15 as result=op_a and flags_out=flags_in with out_err=1; out_err SHALL be 0 for all other opcodes.
REQ-031 SHALL behave identically when WORDS=1 (single-cycle EXEC).

Reset
REQ-032 SHALL on rst force state IDLE, in_ready=1, out_valid=0, result=0, flags_out=0, out_err=0, including mid-EXEC; the pending operation SHALL be discarded.

Structure
REQ-033 SHALL define opcode constants and FSM state encodings in the shared i8080 package/header alongside the existing flag indices.
REQ-034 SHALL use one sub-module, alu_slice (XLEN-wide add/logic slice with carry-in/out and bit-3 carry), instantiated once and reused serially.

Verification (XLEN=8, WORDS=2)
REQ-035 SHALL check ADD 0xFFFF+0x0001 -> result 0x0000, FC=1, FZ=1, FP=1, FA=1, out_valid exactly 2 cycles after accept.
REQ-036 SHALL check SUB 0x1000-0x0001 -> result 0x0FFF, FC=0, FS=0, FZ=0, FP=1.
REQ-037 SHALL check CMP op_a=0x0001, op_b=0x0002 -> result 0x0001, FC=1, FS=1, FZ=0.
REQ-038 SHALL check DAD 0x8000+0x8000 with flags_in FZ=1 -> result 0x0000, FC=1, FZ still 1, other flags unchanged.
REQ-039 SHALL check out_ready held low 3 cycles in DONE -> result and flags stable, in_ready=0, and a new in_valid is not accepted.
REQ-040 SHALL check rst asserted on the first EXEC cycle -> out_valid=0 and in_ready=1 immediately, with no response ever issued for that request.
